// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared constants, FSM state type and address helper for the
// instruction-memory arbiter slice (imem_arbiter_if, imem_sp_ram, imem_arbiter).
package imem_arb_pkg;

    localparam int ADDR_W     = 12;            // byte address width (4 KB)
    localparam int DATA_W     = 32;            // instruction width
    localparam int DEPTH      = 1024;          // words
    localparam int WORD_W     = ADDR_W - 2;    // word index width
    localparam int MAX_STREAK = 4;             // load grants allowed while fetch waits
    localparam int STREAK_W   = 3;             // holds 0..MAX_STREAK

    localparam logic [DATA_W-1:0] NOP_INST = 32'h00000013;  // ADDI x0,x0,0

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    // Byte address to word index; the low two bits never select anything.
    function automatic logic [WORD_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: request/response bundle between the two requesters
// (fetch stage, load/debug port) and the instruction-memory arbiter.
//   master : requester side (drives req/addr/we/wdata, sees gnt/rvalid/rdata)
//   slave  : arbiter side
interface imem_arbiter_if;
    import imem_arb_pkg::*;

    // fetch port (read-only)
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              fetch_misalign;

    // load/debug port (read/write)
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;

    logic              init_done;

    modport master (
        output fetch_req, fetch_addr,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_misalign,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  init_done
    );

    modport slave (
        input  fetch_req, fetch_addr,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_misalign,
        output ld_gnt, ld_rvalid, ld_rdata,
        output init_done
    );

endinterface

// File: rtl/imem_sp_ram.sv
// imem_sp_ram: DEPTH x DATA_W single-port RAM, synchronous read.
// Ports: clk; en (access this cycle); we (1 = write); addr (word index);
// wdata; rdata (registered, updated only by reads, array has no reset).
module imem_sp_ram
    import imem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: owns the 4 KB instruction store and shares it between the
// fetch stage and the program-load/debug port. After every reset the whole
// array is filled with NOP before either requester is admitted.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    imem_arbiter_if.slave (fetch + load ports, init_done)
// Grants are combinational from this cycle's requests; read data returns one
// cycle after the grant on the port that was granted.
module imem_arbiter
    import imem_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    imem_arbiter_if.slave        bus
);

    state_t              state;
    logic [WORD_W-1:0]   fill_cnt;
    logic [STREAK_W-1:0] streak;
    logic                init_done;

    logic                fetch_gnt, ld_gnt;
    logic                fetch_rvalid, ld_rvalid, fetch_misalign;
    logic [DATA_W-1:0]   fetch_hold, ld_hold;

    logic                ram_en, ram_we;
    logic [WORD_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata, ram_rdata;

    logic                run;
    logic                streak_full;
    logic                unused_ld_lsb;

    // Low load-address bits carry no meaning; fetch uses its own for misalign.
    assign unused_ld_lsb = ^bus.ld_addr[1:0];

    // Requests are only seen once the fill is finished, and never while reset
    // is being applied, so nothing reaches the array during a reset cycle.
    assign run         = rst_n && (state == RUN);
    assign streak_full = (streak == STREAK_W'(MAX_STREAK));

    // Load port has priority until it has starved a waiting fetch for
    // MAX_STREAK cycles in a row.
    always_comb begin
        fetch_gnt = 1'b0;
        ld_gnt    = 1'b0;
        if (run) begin
            if (bus.ld_req && !(bus.fetch_req && streak_full)) ld_gnt    = 1'b1;
            else if (bus.fetch_req)                             fetch_gnt = 1'b1;
        end
    end

    // Array port mux: fill writes while in INIT, otherwise the granted port.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = fill_cnt;
        ram_wdata = NOP_INST;
        if (rst_n && (state == INIT)) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
        end else if (ld_gnt) begin
            ram_en    = 1'b1;
            ram_we    = bus.ld_we;
            ram_addr  = word_idx(bus.ld_addr);
            ram_wdata = bus.ld_wdata;
        end else if (fetch_gnt) begin
            ram_en   = 1'b1;
            ram_addr = word_idx(bus.fetch_addr);
        end
    end

    imem_sp_ram u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= INIT;
            fill_cnt       <= '0;
            init_done      <= 1'b0;
            streak         <= '0;
            fetch_rvalid   <= 1'b0;
            ld_rvalid      <= 1'b0;
            fetch_misalign <= 1'b0;
            fetch_hold     <= '0;
            ld_hold        <= '0;
        end else begin
            // The rvalid flags double as the "last grant" select that steers
            // the shared RAM output to the port that issued the read.
            fetch_rvalid   <= fetch_gnt;
            ld_rvalid      <= ld_gnt && !bus.ld_we;
            fetch_misalign <= fetch_gnt && (bus.fetch_addr[1:0] != 2'b00);

            // Capture the delivered word so each port's rdata holds while idle,
            // even when the other port reuses the RAM output register.
            if (fetch_rvalid) fetch_hold <= ram_rdata;
            if (ld_rvalid)    ld_hold    <= ram_rdata;

            case (state)
                INIT: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == WORD_W'(DEPTH - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.fetch_req || fetch_gnt) streak <= '0;
                    else if (ld_gnt && !streak_full)  streak <= streak + 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

    assign bus.fetch_gnt      = fetch_gnt;
    assign bus.ld_gnt         = ld_gnt;
    assign bus.fetch_rvalid   = fetch_rvalid;
    assign bus.ld_rvalid      = ld_rvalid;
    assign bus.fetch_misalign = fetch_misalign;
    assign bus.fetch_rdata    = fetch_rvalid ? ram_rdata : fetch_hold;
    assign bus.ld_rdata       = ld_rvalid    ? ram_rdata : ld_hold;
    assign bus.init_done      = init_done;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: table of per-cycle request vectors with expected
// grants, plus hand-written sequences for streak fairness, init timing and
// reset-mid-operation. Read data is checked through per-port scoreboards fed
// from a reference memory image.
module tb_imem_arbiter;
    import imem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_arbiter_if bus();

    imem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          f_req;
        logic [11:0] f_addr;
        bit          l_req;
        bit          l_we;
        logic [11:0] l_addr;
        logic [31:0] l_wdata;
        bit          f_gnt;
        bit          l_gnt;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        mis;
    } rd_exp_t;

    rd_exp_t     f_q[$];
    rd_exp_t     l_q[$];
    logic [31:0] model [DEPTH];
    logic [31:0] last_f = 32'h0;
    logic [31:0] last_l = 32'h0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    vec_t        tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input bit fr, input logic [11:0] fa, input bit lr, input bit lw,
                                 input logic [11:0] la, input logic [31:0] lwd, input bit fg, input bit lg);
        vec_t v;
        v.f_req = fr; v.f_addr = fa; v.l_req = lr; v.l_we = lw;
        v.l_addr = la; v.l_wdata = lwd; v.f_gnt = fg; v.l_gnt = lg;
        return v;
    endfunction

    function automatic void model_fill();
        for (int i = 0; i < DEPTH; i++) model[i] = NOP_INST;
    endfunction

    // Drive one cycle of requests, check the combinational grants, and record
    // what the granted access should produce.
    task automatic step(input vec_t v, input string tag);
        @(posedge clk); #1;
        bus.fetch_req  = v.f_req;
        bus.fetch_addr = v.f_addr;
        bus.ld_req     = v.l_req;
        bus.ld_we      = v.l_we;
        bus.ld_addr    = v.l_addr;
        bus.ld_wdata   = v.l_wdata;
        #1;
        chk({tag, "_fetch_gnt"}, {31'h0, bus.fetch_gnt}, {31'h0, v.f_gnt});
        chk({tag, "_ld_gnt"}, {31'h0, bus.ld_gnt}, {31'h0, v.l_gnt});
        if (v.f_gnt) f_q.push_back('{model[v.f_addr[11:2]], (v.f_addr[1:0] != 2'b00)});
        if (v.l_gnt) begin
            if (v.l_we) model[v.l_addr[11:2]] = v.l_wdata;
            else        l_q.push_back('{model[v.l_addr[11:2]], 1'b0});
        end
    endtask

    // Count edges from reset release until init_done; optionally try to get
    // grants during the first few fill cycles.
    task automatic wait_init(input bit poke);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        for (int c = 0; c < 1100 && !done; c++) begin
            @(posedge clk); #1;
            n++;
            if (poke && n <= 8) begin
                bus.fetch_req = 1'b1; bus.fetch_addr = 12'h010;
                bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 12'h010; bus.ld_wdata = 32'hBAD0BAD0;
                #1;
                chk("init_fetch_gnt", {31'h0, bus.fetch_gnt}, 32'h0);
                chk("init_ld_gnt", {31'h0, bus.ld_gnt}, 32'h0);
                bus.fetch_req = 1'b0; bus.ld_req = 1'b0;
            end
            if (bus.init_done) done = 1'b1;
        end
        chk("init_done_latency", n, 32'd1024);
        chk("init_done_high", {31'h0, bus.init_done}, 32'h1);
    endtask

    always @(negedge clk) begin : mon
        rd_exp_t e;
        if (mon_en) begin
            if (bus.fetch_rvalid) begin
                if (f_q.size() == 0) chk("fetch_rvalid_unexpected", 32'h1, 32'h0);
                else begin
                    e = f_q.pop_front();
                    chk("fetch_rdata", bus.fetch_rdata, e.data);
                    chk("fetch_misalign", {31'h0, bus.fetch_misalign}, {31'h0, e.mis});
                    last_f = e.data;
                end
            end else begin
                chk("fetch_rdata_hold", bus.fetch_rdata, last_f);
                chk("fetch_misalign_idle", {31'h0, bus.fetch_misalign}, 32'h0);
            end
            if (bus.ld_rvalid) begin
                if (l_q.size() == 0) chk("ld_rvalid_unexpected", 32'h1, 32'h0);
                else begin
                    e = l_q.pop_front();
                    chk("ld_rdata", bus.ld_rdata, e.data);
                    last_l = e.data;
                end
            end else begin
                chk("ld_rdata_hold", bus.ld_rdata, last_l);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mkv(1'b1, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);         // word 0 = NOP
        tbl[1]  = mkv(1'b1, 12'h7FC, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);         // word 511
        tbl[2]  = mkv(1'b1, 12'hFFC, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);         // word 1023
        tbl[3]  = mkv(1'b0, 12'h000, 1'b1, 1'b1, 12'h004, 32'h00208233, 1'b0, 1'b1); // write word 1
        tbl[4]  = mkv(1'b1, 12'h004, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);         // read-after-write
        tbl[5]  = mkv(1'b1, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
        tbl[6]  = mkv(1'b1, 12'h004, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
        tbl[7]  = mkv(1'b1, 12'h008, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
        tbl[8]  = mkv(1'b1, 12'h006, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);         // misaligned
        tbl[9]  = mkv(1'b0, 12'h000, 1'b1, 1'b1, 12'h7FC, 32'hCAFEF00D, 1'b0, 1'b1);
        tbl[10] = mkv(1'b0, 12'h000, 1'b1, 1'b0, 12'h7FC, 32'h0, 1'b0, 1'b1);
        tbl[11] = mkv(1'b0, 12'h000, 1'b1, 1'b0, 12'hFFC, 32'h0, 1'b0, 1'b1);
        tbl[12] = mkv(1'b1, 12'h100, 1'b1, 1'b0, 12'h008, 32'h0, 1'b0, 1'b1);         // both: load wins
        tbl[13] = mkv(1'b1, 12'h100, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
        tbl[14] = mkv(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);

        bus.fetch_req = 1'b0; bus.fetch_addr = 12'h0;
        bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = 12'h0; bus.ld_wdata = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fetch_gnt", {31'h0, bus.fetch_gnt}, 32'h0);
        chk("rst_ld_gnt", {31'h0, bus.ld_gnt}, 32'h0);
        chk("rst_fetch_rvalid", {31'h0, bus.fetch_rvalid}, 32'h0);
        chk("rst_ld_rvalid", {31'h0, bus.ld_rvalid}, 32'h0);
        chk("rst_fetch_misalign", {31'h0, bus.fetch_misalign}, 32'h0);
        chk("rst_init_done", {31'h0, bus.init_done}, 32'h0);
        chk("rst_fetch_rdata", bus.fetch_rdata, 32'h0);
        chk("rst_ld_rdata", bus.ld_rdata, 32'h0);
        mon_en = 1'b1;
        rst_n = 1'b1;
        model_fill();
        wait_init(1'b0);

        for (int i = 0; i < 15; i++) step(tbl[i], "tbl");

        // Both requesters held: four load grants, then fetch, repeating.
        for (int i = 0; i < 10; i++)
            step(mkv(1'b1, 12'h000, 1'b1, 1'b0, 12'h008, 32'h0, (i % 5 == 4), (i % 5 != 4)), "streak");
        step(tbl[14], "idle");

        // Reset with a load read outstanding, after overwriting word 4.
        step(mkv(1'b0, 12'h000, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 1'b1), "rst_wr");
        step(mkv(1'b0, 12'h000, 1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b1), "rst_rd");
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.fetch_req = 1'b0; bus.ld_req = 1'b0; bus.ld_we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_f = 32'h0;
        last_l = 32'h0;
        chk("post_rst_ld_rvalid", {31'h0, bus.ld_rvalid}, 32'h0);
        chk("post_rst_fetch_rvalid", {31'h0, bus.fetch_rvalid}, 32'h0);
        chk("post_rst_init_done", {31'h0, bus.init_done}, 32'h0);
        chk("post_rst_ld_rdata", bus.ld_rdata, 32'h0);
        model_fill();
        wait_init(1'b1);
        step(mkv(1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0), "refill_rd");
        step(tbl[14], "idle");
        repeat (3) @(posedge clk);
        #1;
        chk("fetch_q_drained", f_q.size(), 32'h0);
        chk("ld_q_drained", l_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
